// File: rtl/stream_operand_loader.sv
// Operand loader that serialises two held operands LSB first, followed by
// zero or sign extension bits, as one framed bit stream per start request.
module stream_operand_loader #(
    parameter int WIDTH  = 8,
    parameter int EXT    = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             start,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int FRAME = WIDTH + EXT;
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Handshake: start is sampled only when ena=1 and the FSM is IDLE; every
    // enabled STREAM cycle presents exactly one frame bit qualified by
    // bit_valid, and done pulses on the first enabled cycle after the last bit.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_a, hold_b;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             accept, last_cycle;
    logic             fill_a, fill_b;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_cycle = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && start) begin
                    accept  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (ena && (cnt_q == LAST_IDX)) begin
                    last_cycle = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Shifting in the MSB makes every bit after the operand a sign copy.
    assign fill_a = (SIGNED != 0) ? sh_a[WIDTH-1] : 1'b0;
    assign fill_b = (SIGNED != 0) ? sh_b[WIDTH-1] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a <= '0;
            hold_b <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (ena) begin
            if (load_a) hold_a <= data_in;
            if (load_b) hold_b <= data_in;
            done_q <= last_cycle;
            if (accept) begin
                sh_a  <= hold_a;
                sh_b  <= hold_b;
                cnt_q <= '0;
            end else if (state_q == STREAM) begin
                sh_a  <= {fill_a, sh_a[WIDTH-1:1]};
                sh_b  <= {fill_b, sh_b[WIDTH-1:1]};
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bit_valid = ena && (state_q == STREAM);
    assign first_bit = bit_valid && (cnt_q == '0);
    assign last_bit  = bit_valid && (cnt_q == LAST_IDX);
    assign a_bit     = bit_valid && sh_a[0];
    assign b_bit     = bit_valid && sh_b[0];
    assign busy      = (state_q == STREAM);
    assign done      = ena && done_q;

endmodule

// File: tb/tb_stream_operand_loader.sv
// Bench for stream_operand_loader: an unsigned and a signed instance share all
// inputs; a negedge monitor pops expected {a,b,first,last} tuples per instance.
module tb_stream_operand_loader;

    localparam int W     = 8;
    localparam int E     = 8;
    localparam int FRAME = W + E;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         load_a = 1'b0, load_b = 1'b0, start = 1'b0;

    logic a0, b0, v0, f0, l0, busy0, done0;
    logic a1, b1, v1, f1, l1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp0_q[$];
    logic [3:0] exp1_q[$];
    logic [W-1:0] hold_a_m = '0, hold_b_m = '0;

    always #5 clk = ~clk;

    stream_operand_loader #(.WIDTH(W), .EXT(E), .SIGNED(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in),
        .load_a(load_a), .load_b(load_b), .start(start),
        .a_bit(a0), .b_bit(b0), .bit_valid(v0), .first_bit(f0),
        .last_bit(l0), .busy(busy0), .done(done0)
    );

    stream_operand_loader #(.WIDTH(W), .EXT(E), .SIGNED(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in),
        .load_a(load_a), .load_b(load_b), .start(start),
        .a_bit(a1), .b_bit(b1), .bit_valid(v1), .first_bit(f1),
        .last_bit(l1), .busy(busy1), .done(done1)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n) begin
            vectors++;
            if (v0) begin
                if (exp0_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL dut0_unexpected_bit got=%b%b%b%b required=no_bit", a0, b0, f0, l0);
                end else begin
                    e = exp0_q.pop_front();
                    if ({a0, b0, f0, l0} !== e) begin
                        miscompares++;
                        $display("FAIL dut0_frame_bit got=%b required=%b t=%0t", {a0, b0, f0, l0}, e, $time);
                    end
                end
            end else if ({a0, b0, f0, l0} !== 4'b0000) begin
                miscompares++;
                $display("FAIL dut0_idle_outputs got=%b required=0000 t=%0t", {a0, b0, f0, l0}, $time);
            end
            vectors++;
            if (v1) begin
                if (exp1_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL dut1_unexpected_bit got=%b%b%b%b required=no_bit", a1, b1, f1, l1);
                end else begin
                    e = exp1_q.pop_front();
                    if ({a1, b1, f1, l1} !== e) begin
                        miscompares++;
                        $display("FAIL dut1_frame_bit got=%b required=%b t=%0t", {a1, b1, f1, l1}, e, $time);
                    end
                end
            end else if ({a1, b1, f1, l1} !== 4'b0000) begin
                miscompares++;
                $display("FAIL dut1_idle_outputs got=%b required=0000 t=%0t", {a1, b1, f1, l1}, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < FRAME; i++) begin
            logic ua, ub, sa, sb;
            ua = (i < W) ? a[i] : 1'b0;
            ub = (i < W) ? b[i] : 1'b0;
            sa = (i < W) ? a[i] : a[W-1];
            sb = (i < W) ? b[i] : b[W-1];
            exp0_q.push_back({ua, ub, i == 0, i == FRAME - 1});
            exp1_q.push_back({sa, sb, i == 0, i == FRAME - 1});
        end
    endtask

    task automatic load_op(input bit which_b, input logic [W-1:0] val);
        data_in = val;
        load_a  = !which_b;
        load_b  = which_b;
        tick();
        load_a  = 1'b0;
        load_b  = 1'b0;
        if (which_b) hold_b_m = val;
        else         hold_a_m = val;
    endtask

    task automatic start_frame();
        push_frame(hold_a_m, hold_b_m);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle index (relative to the accepting edge) of done, or -1.
    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done0) return;
            @(posedge clk);
            #1;
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a0, b0, v0, f0, l0, busy0, done0, a1, b1, v1, f1, l1, busy1, done1} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b required=0",
                     {a0, b0, v0, f0, l0, busy0, done0, a1, b1, v1, f1, l1, busy1, done1});
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if ({busy0, busy1, done0, done1} !== 4'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle got=%b required=0000", {busy0, busy1, done0, done1});
        end
    endtask

    task automatic test_basic();
        int c;
        load_op(1'b0, 8'hB5);
        load_op(1'b1, 8'h03);
        start_frame();
        vectors++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy got=%b%b required=11", busy0, busy1);
        end
        wait_done(1, c);
        vectors++;
        if (c !== FRAME + 1) begin
            miscompares++;
            $display("FAIL basic_done_cycle got=%0d required=%0d", c, FRAME + 1);
        end
        vectors++;
        if ({busy0, busy1, done1} !== 3'b001) begin
            miscompares++;
            $display("FAIL basic_done_state got=%b required=001", {busy0, busy1, done1});
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({done0, done1} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_done_pulse got=%b required=00", {done0, done1});
        end
        tick();
    endtask

    task automatic test_signed();
        int c;
        load_op(1'b0, 8'h80);
        load_op(1'b1, 8'h7F);
        start_frame();
        wait_done(1, c);
        vectors++;
        if (c !== FRAME + 1 || exp0_q.size() != 0 || exp1_q.size() != 0) begin
            miscompares++;
            $display("FAIL signed_frame_len got=%0d left=%0d/%0d required=%0d left=0/0",
                     c, exp0_q.size(), exp1_q.size(), FRAME + 1);
        end
        tick();
    endtask

    task automatic test_load_during_frame();
        int c;
        start_frame();
        for (int k = 1; k < 10; k++) begin
            if (k == 3) begin
                data_in = 8'h55;
                load_a  = 1'b1;
            end
            start = (k == 5 || k == 8);
            tick();
            load_a = 1'b0;
            start  = 1'b0;
        end
        hold_a_m = 8'h55;
        wait_done(10, c);
        vectors++;
        if (c !== FRAME + 1) begin
            miscompares++;
            $display("FAIL busy_start_done_cycle got=%0d required=%0d", c, FRAME + 1);
        end
        push_frame(hold_a_m, hold_b_m);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, c);
        vectors++;
        if (c !== FRAME + 1 || exp0_q.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_back_done got=%0d left=%0d required=%0d left=0",
                     c, exp0_q.size(), FRAME + 1);
        end
        tick();
    endtask

    task automatic test_stall();
        int c;
        start_frame();
        repeat (5) tick();
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({v0, v1, busy0, busy1, done0} !== 5'b00110) begin
                miscompares++;
                $display("FAIL stall_outputs got=%b required=00110", {v0, v1, busy0, busy1, done0});
            end
            @(posedge clk);
            #1;
        end
        ena = 1'b1;
        wait_done(9, c);
        vectors++;
        if (c !== FRAME + 4 || exp0_q.size() != 0 || exp1_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_done got=%0d left=%0d required=%0d left=0",
                     c, exp0_q.size(), FRAME + 4);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        int dones;
        start_frame();
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({a0, b0, v0, f0, l0, busy0, done0, a1, b1, v1, busy1} !== 11'b0) begin
            miscompares++;
            $display("FAIL async_reset_outputs got=%b required=0",
                     {a0, b0, v0, f0, l0, busy0, done0, a1, b1, v1, busy1});
        end
        exp0_q.delete();
        exp1_q.delete();
        hold_a_m = '0;
        hold_b_m = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done0 || done1 || busy0 || busy1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_abort_no_done got=%0d required=0", dones);
        end
        tick();
        start_frame();
        wait_done(1, c);
        vectors++;
        if (c !== FRAME + 1) begin
            miscompares++;
            $display("FAIL after_reset_frame got=%0d required=%0d", c, FRAME + 1);
        end
        tick();
    endtask

    task automatic test_load_start_same();
        int c;
        load_op(1'b0, 8'h3C);
        load_op(1'b1, 8'hA5);
        push_frame(hold_a_m, hold_b_m);
        data_in = 8'hC3;
        load_a  = 1'b1;
        start   = 1'b1;
        tick();
        load_a  = 1'b0;
        start   = 1'b0;
        hold_a_m = 8'hC3;
        wait_done(1, c);
        vectors++;
        if (c !== FRAME + 1) begin
            miscompares++;
            $display("FAIL same_cycle_first got=%0d required=%0d", c, FRAME + 1);
        end
        push_frame(hold_a_m, hold_b_m);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, c);
        vectors++;
        if (c !== FRAME + 1) begin
            miscompares++;
            $display("FAIL same_cycle_second got=%0d required=%0d", c, FRAME + 1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_load_during_frame();
        test_stall();
        test_reset_mid();
        test_load_start_same();
        repeat (3) tick();
        vectors++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drained got=%0d/%0d required=0/0", exp0_q.size(), exp1_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
